nim_turn_controller: RTL and testbench

- Game-state core of the Nim game. Consumes the single-cycle button pulses produced by the per-button synchronizer/one-shot FSMs.
- Holds three pile counts and the current player. The player picks a pile and a take amount, then confirms; the block validates the move and applies it.
- Detects end of game (normal play: whoever takes the last object wins). Drives the display/LED logic downstream.

---
 rtl/nim_turn_controller.sv | 179 +++++++++++++++++
 tb/tb_nim_turn_controller.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nim_turn_controller.sv
`default_nettype none
// ============================================================================
// Module   : nim_turn_controller
// Purpose  : Nim game-state core; validates and applies moves on three piles.
// Revision : 1.0 - initial release
// ============================================================================
module nim_turn_controller #(
    parameter int PW       = 4,
    parameter int INIT0    = 3,
    parameter int INIT1    = 5,
    parameter int INIT2    = 7,
    parameter int MAX_TAKE = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_new_game,
    input  logic          i_pile_next,
    input  logic          i_take_inc,
    input  logic          i_take_dec,
    input  logic          i_confirm,
    output logic [PW-1:0] o_pile0,
    output logic [PW-1:0] o_pile1,
    output logic [PW-1:0] o_pile2,
    output logic [1:0]    o_sel_pile,
    output logic [PW-1:0] o_take,
    output logic          o_player,
    output logic          o_move_valid,
    output logic          o_move_reject,
    output logic          o_game_over,
    output logic          o_winner
);

    localparam logic [PW-1:0] c_init0    = PW'(INIT0);
    localparam logic [PW-1:0] c_init1    = PW'(INIT1);
    localparam logic [PW-1:0] c_init2    = PW'(INIT2);
    localparam logic [PW-1:0] c_max_take = PW'(MAX_TAKE);
    localparam logic [PW-1:0] c_one      = PW'(1);

    typedef enum logic [1:0] {
        ST_SELECT = 2'd0,
        ST_APPLY  = 2'd1,
        ST_OVER   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] pile0_q, pile0_d;
    logic [PW-1:0] pile1_q, pile1_d;
    logic [PW-1:0] pile2_q, pile2_d;
    logic [1:0]    sel_q, sel_d;
    logic [PW-1:0] take_q, take_d;
    logic          player_q, player_d;
    logic          valid_q, valid_d;
    logic          reject_q, reject_d;
    logic          over_q, over_d;
    logic          winner_q, winner_d;

    logic [PW-1:0] w_cur_pile;
    logic [PW-1:0] w_left;
    logic          w_last_move;

    always_comb begin
        case (sel_q)
            2'd1:    w_cur_pile = pile1_q;
            2'd2:    w_cur_pile = pile2_q;
            default: w_cur_pile = pile0_q;
        endcase
    end

    // Safe from underflow: APPLY is only entered when the pile holds >= take.
    assign w_left = w_cur_pile - take_q;

    assign w_last_move = (w_left == '0) &&
                         ((sel_q == 2'd0) || (pile0_q == '0)) &&
                         ((sel_q == 2'd1) || (pile1_q == '0)) &&
                         ((sel_q == 2'd2) || (pile2_q == '0));

    always_comb begin
        state_d  = state_q;
        pile0_d  = pile0_q;
        pile1_d  = pile1_q;
        pile2_d  = pile2_q;
        sel_d    = sel_q;
        take_d   = take_q;
        player_d = player_q;
        over_d   = over_q;
        winner_d = winner_q;
        valid_d  = 1'b0;
        reject_d = 1'b0;

        if (i_new_game) begin
            state_d  = ST_SELECT;
            pile0_d  = c_init0;
            pile1_d  = c_init1;
            pile2_d  = c_init2;
            sel_d    = 2'd0;
            take_d   = c_one;
            player_d = 1'b0;
            over_d   = 1'b0;
            winner_d = 1'b0;
        end else begin
            case (state_q)
                ST_SELECT: begin
                    if (i_confirm) begin
                        if (w_cur_pile >= take_q) begin
                            state_d = ST_APPLY;
                        end else begin
                            reject_d = 1'b1;
                        end
                    end else if (i_pile_next) begin
                        sel_d = (sel_q == 2'd2) ? 2'd0 : sel_q + 2'd1;
                    end else if (i_take_inc && !i_take_dec) begin
                        if (take_q < c_max_take) take_d = take_q + c_one;
                    end else if (i_take_dec && !i_take_inc) begin
                        if (take_q > c_one) take_d = take_q - c_one;
                    end
                end
                ST_APPLY: begin
                    case (sel_q)
                        2'd1:    pile1_d = w_left;
                        2'd2:    pile2_d = w_left;
                        default: pile0_d = w_left;
                    endcase
                    take_d  = c_one;
                    valid_d = 1'b1;
                    if (w_last_move) begin
                        state_d  = ST_OVER;
                        over_d   = 1'b1;
                        winner_d = player_q;
                    end else begin
                        state_d  = ST_SELECT;
                        player_d = ~player_q;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_SELECT;
            pile0_q  <= c_init0;
            pile1_q  <= c_init1;
            pile2_q  <= c_init2;
            sel_q    <= 2'd0;
            take_q   <= c_one;
            player_q <= 1'b0;
            valid_q  <= 1'b0;
            reject_q <= 1'b0;
            over_q   <= 1'b0;
            winner_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pile0_q  <= pile0_d;
            pile1_q  <= pile1_d;
            pile2_q  <= pile2_d;
            sel_q    <= sel_d;
            take_q   <= take_d;
            player_q <= player_d;
            valid_q  <= valid_d;
            reject_q <= reject_d;
            over_q   <= over_d;
            winner_q <= winner_d;
        end
    end

    assign o_pile0       = pile0_q;
    assign o_pile1       = pile1_q;
    assign o_pile2       = pile2_q;
    assign o_sel_pile    = sel_q;
    assign o_take        = take_q;
    assign o_player      = player_q;
    assign o_move_valid  = valid_q;
    assign o_move_reject = reject_q;
    assign o_game_over   = over_q;
    assign o_winner      = winner_q;

endmodule
`default_nettype wire

// File: tb/tb_nim_turn_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_nim_turn_controller
// Purpose  : Directed self-checking bench with a move-level game model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nim_turn_controller;

    localparam int PW   = 4;
    localparam int MAXT = 3;

    logic          clk;
    logic          rst_n;
    logic          i_new_game, i_pile_next, i_take_inc, i_take_dec, i_confirm;
    logic [PW-1:0] o_pile0, o_pile1, o_pile2, o_take;
    logic [1:0]    o_sel_pile;
    logic          o_player, o_move_valid, o_move_reject, o_game_over, o_winner;

    int checks = 0;
    int errors = 0;

    nim_turn_controller #(
        .PW(PW), .INIT0(3), .INIT1(5), .INIT2(7), .MAX_TAKE(MAXT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_new_game   (i_new_game),
        .i_pile_next  (i_pile_next),
        .i_take_inc   (i_take_inc),
        .i_take_dec   (i_take_dec),
        .i_confirm    (i_confirm),
        .o_pile0      (o_pile0),
        .o_pile1      (o_pile1),
        .o_pile2      (o_pile2),
        .o_sel_pile   (o_sel_pile),
        .o_take       (o_take),
        .o_player     (o_player),
        .o_move_valid (o_move_valid),
        .o_move_reject(o_move_reject),
        .o_game_over  (o_game_over),
        .o_winner     (o_winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Game model: a confirmed legal move is remembered and lands one edge later.
    int m_pile[3];
    int m_sel, m_take, m_player, m_over, m_winner, m_valid, m_reject;
    bit m_pending;

    task automatic m_restart();
        m_pile[0] = 3; m_pile[1] = 5; m_pile[2] = 7;
        m_sel = 0; m_take = 1; m_player = 0;
        m_over = 0; m_winner = 0; m_valid = 0; m_reject = 0;
        m_pending = 1'b0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_restart();
        end else begin
            m_valid = 0;
            m_reject = 0;
            if (i_new_game) begin
                m_restart();
            end else if (m_pending) begin
                m_pending = 1'b0;
                m_pile[m_sel] -= m_take;
                m_take = 1;
                m_valid = 1;
                if (m_pile[0] + m_pile[1] + m_pile[2] == 0) begin
                    m_over = 1;
                    m_winner = m_player;
                end else begin
                    m_player = 1 - m_player;
                end
            end else if (m_over != 0) begin
                // frozen until a new game
            end else if (i_confirm) begin
                if (m_pile[m_sel] >= m_take) m_pending = 1'b1;
                else m_reject = 1;
            end else if (i_pile_next) begin
                m_sel = (m_sel + 1) % 3;
            end else if (i_take_inc && !i_take_dec) begin
                m_take = (m_take < MAXT) ? m_take + 1 : MAXT;
            end else if (i_take_dec && !i_take_inc) begin
                m_take = (m_take > 1) ? m_take - 1 : 1;
            end
        end
    end

    always @(negedge clk) begin
        chk("pile0", int'(o_pile0), m_pile[0]);
        chk("pile1", int'(o_pile1), m_pile[1]);
        chk("pile2", int'(o_pile2), m_pile[2]);
        chk("sel", int'(o_sel_pile), m_sel);
        chk("take", int'(o_take), m_take);
        chk("player", int'(o_player), m_player);
        chk("move_valid", int'(o_move_valid), m_valid);
        chk("move_reject", int'(o_move_reject), m_reject);
        chk("game_over", int'(o_game_over), m_over);
        if (m_over != 0) chk("winner", int'(o_winner), m_winner);
    end

    task automatic drive(input bit ng, input bit nx, input bit inc, input bit dec, input bit cf);
        @(negedge clk); #1;
        i_new_game = ng; i_pile_next = nx; i_take_inc = inc; i_take_dec = dec; i_confirm = cf;
        @(posedge clk); #1;
        i_new_game = 0; i_pile_next = 0; i_take_inc = 0; i_take_dec = 0; i_confirm = 0;
    endtask

    task automatic nxt(input int n);
        for (int k = 0; k < n; k++) drive(0, 1, 0, 0, 0);
    endtask
    task automatic inc(input int n);
        for (int k = 0; k < n; k++) drive(0, 0, 1, 0, 0);
    endtask
    task automatic dec(input int n);
        for (int k = 0; k < n; k++) drive(0, 0, 0, 1, 0);
    endtask
    // select pile, set take from 1, confirm, then let the APPLY edge pass
    task automatic move(input int steps_next, input int take);
        nxt(steps_next);
        inc(take - 1);
        drive(0, 0, 0, 0, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 0;
        i_new_game = 0; i_pile_next = 0; i_take_inc = 0; i_take_dec = 0; i_confirm = 0;
        repeat (2) @(negedge clk);
        chk("rst_pile0", int'(o_pile0), 3);
        chk("rst_pile1", int'(o_pile1), 5);
        chk("rst_pile2", int'(o_pile2), 7);
        chk("rst_take", int'(o_take), 1);
        chk("rst_over", int'(o_game_over), 0);
        rst_n = 1;

        inc(4);
        @(negedge clk); chk("take_sat_hi", int'(o_take), 3);
        dec(5);
        @(negedge clk); chk("take_sat_lo", int'(o_take), 1);
        inc(1);
        drive(0, 0, 1, 1, 0);
        @(negedge clk); chk("take_incdec", int'(o_take), 2);
        dec(1);
        nxt(4);
        @(negedge clk); chk("sel_wrap", int'(o_sel_pile), 1);
        nxt(2);

        // player 0 empties pile0 with take 3
        inc(2);
        drive(0, 0, 0, 0, 1);
        @(negedge clk);
        chk("apply_pending_pile0", int'(o_pile0), 3);
        chk("apply_pending_valid", int'(o_move_valid), 0);
        @(negedge clk);
        chk("applied_pile0", int'(o_pile0), 0);
        chk("applied_valid", int'(o_move_valid), 1);
        chk("applied_player", int'(o_player), 1);
        chk("applied_take", int'(o_take), 1);

        // confirm on empty pile
        drive(0, 0, 0, 0, 1);
        @(negedge clk); chk("reject_empty", int'(o_move_reject), 1);
        @(negedge clk); chk("reject_one_cycle", int'(o_move_reject), 0);

        move(1, 3);                       // p1: pile1 5->2
        inc(2);
        drive(0, 0, 0, 0, 1);             // p0: take 3 from 2 -> reject
        @(negedge clk); chk("reject_short", int'(o_move_reject), 1);
        dec(1);
        drive(0, 0, 0, 0, 1);             // p0: take 2 from pile1 -> 0
        @(posedge clk); #1;
        move(1, 3);                       // p1: pile2 7->4
        move(0, 3);                       // p0: pile2 4->1
        move(0, 1);                       // p1: pile2 1->0, last object
        @(negedge clk);
        chk("over_flag", int'(o_game_over), 1);
        chk("over_winner", int'(o_winner), 1);
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 1, 0, 0);
        drive(0, 1, 0, 0, 0);
        @(negedge clk);
        chk("over_no_reject", int'(o_move_reject), 0);
        chk("over_sel_frozen", int'(o_sel_pile), 2);

        // new game during APPLY
        drive(1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1);
        drive(1, 0, 0, 0, 0);
        @(negedge clk);
        chk("ng_apply_pile0", int'(o_pile0), 3);
        chk("ng_apply_valid", int'(o_move_valid), 0);
        chk("ng_apply_player", int'(o_player), 0);

        // new game beats confirm in the same cycle
        move(0, 1);
        drive(1, 0, 1, 0, 1);
        @(negedge clk);
        chk("ng_cf_pile0", int'(o_pile0), 3);
        chk("ng_cf_player", int'(o_player), 0);
        chk("ng_cf_take", int'(o_take), 1);
        @(negedge clk); chk("ng_cf_no_valid", int'(o_move_valid), 0);

        // held confirm: at most one APPLY per two cycles
        nxt(2);
        @(negedge clk); #1;
        i_confirm = 1;
        repeat (4) @(posedge clk);
        #1 i_confirm = 0;
        @(negedge clk); chk("held_cf_pile2", int'(o_pile2), 5);

        // asynchronous reset mid-cycle
        inc(2);
        @(posedge clk); #2;
        rst_n = 0;
        #1;
        chk("async_pile2", int'(o_pile2), 7);
        chk("async_take", int'(o_take), 1);
        chk("async_sel", int'(o_sel_pile), 0);
        @(negedge clk); rst_n = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
